// File: rtl/cnt_pkg.sv
// cnt_pkg: shared types and constants for the counter capture controller
package cnt_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_e;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
  localparam int CNT_WIDTH_DEF = 8;
endpackage

// File: rtl/evt_sync_edge.sv
// evt_sync_edge: synchronizes the async event pin and emits a registered 1-cycle edge pulse
module evt_sync_edge import cnt_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_SEL = EDGE_RISE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic evt_i,
  output logic evt_edge_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic hist_q, edge_q, rise, fall, edge_d;
  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;
  assign edge_d = (EDGE_SEL == EDGE_BOTH) ? (rise | fall) : (EDGE_SEL == EDGE_FALL) ? fall : rise;
  assign evt_edge_o = edge_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], evt_i};
      hist_q <= sync_q[SYNC_STAGES-1];
      edge_q <= edge_d;
    end
  end
endmodule

// File: rtl/cnt_capture_ctrl.sv
// cnt_capture_ctrl: arms the counter on qualified event edges and captures the count into a 1-entry slot
module cnt_capture_ctrl import cnt_pkg::*; #(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_SEL = EDGE_RISE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 arm_i,
  input  logic                 evt_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  input  logic                 ovf_i,
  output logic                 cnt_en_o,
  output logic                 cnt_clr_o,
  output logic [CNT_WIDTH-1:0] cap_data_o,
  output logic                 cap_ovf_o,
  output logic                 cap_valid_o,
  input  logic                 cap_ready_i,
  output logic                 busy_o,
  output logic                 lost_o
);
  state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] data_q, data_d;
  logic ovf_q, ovf_d, valid_q, valid_d, lost_q, lost_d;
  logic evt_edge, en, clr, cap, load, arm_start;
  evt_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_SEL(EDGE_SEL)) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .evt_i(evt_i),
    .evt_edge_o(evt_edge)
  );
  always_comb begin
    state_d = state_q;
    en = 1'b0;
    clr = 1'b0;
    cap = 1'b0;
    case (state_q)
      IDLE: if (arm_i) begin
        state_d = ARMED;
        clr = 1'b1;
      end
      ARMED: if (!arm_i) state_d = IDLE;
        else if (evt_edge) begin
          state_d = RUN;
          clr = 1'b1;
        end
      RUN: if (!arm_i) state_d = IDLE;
        else begin
          en = 1'b1;
          clr = evt_edge;
          cap = evt_edge;
        end
      default: state_d = IDLE;
    endcase
  end
  // A capture lands if the slot is empty or is being drained in the same cycle.
  assign arm_start = (state_q == IDLE) & arm_i;
  assign load = cap & (~valid_q | cap_ready_i);
  assign valid_d = load | (valid_q & ~cap_ready_i);
  assign data_d = load ? cnt_i : data_q;
  assign ovf_d = load ? ovf_i : ovf_q;
  assign lost_d = arm_start ? 1'b0 : lost_q | (cap & valid_q & ~cap_ready_i);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
      lost_q <= lost_d;
    end
  end
  assign cnt_en_o = en & ~rst_i;
  assign cnt_clr_o = clr & ~rst_i;
  assign cap_data_o = data_q;
  assign cap_ovf_o = ovf_q;
  assign cap_valid_o = valid_q;
  assign busy_o = state_q != IDLE;
  assign lost_o = lost_q;
endmodule

// File: tb/tb_cnt_capture_ctrl.sv
// tb_cnt_capture_ctrl: directed/randomized checks of capture control against an edge-interval reference model
module tb_cnt_capture_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic arm = 1'b0, evt = 1'b0, rdy = 1'b1;
  logic [7:0] cnt_a = '0, data_a;
  logic ovf_a = 1'b0, en_a, clr_a, capovf_a, valid_a, busy_a, lost_a;
  logic arm_b = 1'b0, evt_b = 1'b0;
  logic [7:0] cnt_b = '0, data_b;
  logic ovf_b = 1'b0, en_b, clr_b, capovf_b, valid_b, busy_b, lost_b;
  int n_cmp = 0, n_err = 0, last_p = 0;
  logic exp_valid = 1'b0, exp_ovf = 1'b0, exp_lost = 1'b0;
  logic [7:0] exp_data = '0;
  always #5 clk = ~clk;
  cnt_capture_ctrl #(.CNT_WIDTH(8), .SYNC_STAGES(2), .EDGE_SEL(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .evt_i(evt), .cnt_i(cnt_a), .ovf_i(ovf_a),
    .cnt_en_o(en_a), .cnt_clr_o(clr_a), .cap_data_o(data_a), .cap_ovf_o(capovf_a),
    .cap_valid_o(valid_a), .cap_ready_i(rdy), .busy_o(busy_a), .lost_o(lost_a)
  );
  cnt_capture_ctrl #(.CNT_WIDTH(8), .SYNC_STAGES(2), .EDGE_SEL(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .arm_i(arm_b), .evt_i(evt_b), .cnt_i(cnt_b), .ovf_i(ovf_b),
    .cnt_en_o(en_b), .cnt_clr_o(clr_b), .cap_data_o(data_b), .cap_ovf_o(capovf_b),
    .cap_valid_o(valid_b), .cap_ready_i(1'b1), .busy_o(busy_b), .lost_o(lost_b)
  );
  // External counters: clear beats enable, sticky overflow on wrap
  always @(posedge clk) begin
    if (clr_a) begin cnt_a <= '0; ovf_a <= 1'b0; end
    else if (en_a) begin cnt_a <= cnt_a + 8'd1; if (cnt_a == 8'hff) ovf_a <= 1'b1; end
    if (clr_b) begin cnt_b <= '0; ovf_b <= 1'b0; end
    else if (en_b) begin cnt_b <= cnt_b + 8'd1; if (cnt_b == 8'hff) ovf_b <= 1'b1; end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // One rising edge at k=0, then p cycles until the next call's edge.
  // The capture at this edge measures the previous interval last_p.
  task automatic period(input int p, input bit cap, input bit rd, input bit rd_e, input bit drop);
    logic [7:0] nd;
    logic no;
    nd = 8'((last_p - 1) % 256);
    no = (last_p - 1) >= 256;
    for (int k = 0; k < p; k++) begin
      @(negedge clk);
      if (k == 0) begin evt = 1'b1; rdy = rd; end
      if (k == p / 2) evt = 1'b0;
      if (k == 3) begin rdy = rd_e; if (drop) arm = 1'b0; end
      if (k == 4) rdy = rd;
      #1;
      if (k == 0 && rd) exp_valid = 1'b0;
      if (k == 1) chk("valid_pre", valid_a, exp_valid);
      if (k == 3) begin
        chk("clr_at_e", clr_a, !drop);
        chk("en_at_e", en_a, cap && !drop);
        if (cap && !drop) begin
          if (!exp_valid || rd_e) begin exp_valid = 1'b1; exp_data = nd; exp_ovf = no; end
          else exp_lost = 1'b1;
        end else if (rd_e) exp_valid = 1'b0;
      end
      if (k == 4) begin
        chk("valid_post", valid_a, exp_valid);
        if (exp_valid) begin
          chk("cap_data", data_a, exp_data);
          chk("cap_ovf", capovf_a, exp_ovf);
        end
        chk("lost", lost_a, exp_lost);
        chk("busy", busy_a, !drop);
        chk("en_after", en_a, !drop);
        if (rd) exp_valid = 1'b0;
      end
    end
    last_p = p;
  endtask
  initial begin
    int lens [5] = '{10, 30, 10, 30, 10};
    repeat (3) @(negedge clk);
    #1;
    chk("rst_clr", clr_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_lost", lost_a, 0);
    chk("rst_data", data_a, 0);
    // 1: arm, rising edges 20 apart
    @(negedge clk); rst = 1'b0;
    @(negedge clk); arm = 1'b1; #1;
    chk("arm_clr", clr_a, 1);
    chk("arm_en", en_a, 0);
    @(negedge clk); #1;
    chk("armed_clr", clr_a, 0);
    chk("armed_busy", busy_a, 1);
    period(20, 0, 1, 1, 0);
    repeat (3) period(20, 1, 1, 1, 0);
    // 2: 300-cycle intervals wrap the counter
    repeat (2) period(300, 1, 1, 1, 0);
    // 4: slot full, new capture coincides with a transfer
    period($urandom_range(10, 60), 1, 0, 0, 0);
    period($urandom_range(10, 60), 1, 0, 1, 0);
    // 3: slot full with ready low drops captures
    repeat (3) period($urandom_range(10, 60), 1, 0, 0, 0);
    period($urandom_range(10, 60), 1, 1, 1, 0);
    // 5: arm drop coinciding with an edge, then re-arm and reset in RUN
    period(20, 1, 1, 1, 1);
    @(negedge clk); arm = 1'b1; #1;
    chk("rearm_clr", clr_a, 1);
    exp_lost = 1'b0;
    @(negedge clk); #1;
    chk("rearm_lost", lost_a, 0);
    chk("rearm_busy", busy_a, 1);
    period(20, 0, 1, 1, 0);
    period($urandom_range(10, 60), 1, 1, 1, 0);
    @(negedge clk); rst = 1'b1; arm = 1'b0;
    @(negedge clk); #1;
    chk("rrun_en", en_a, 0);
    chk("rrun_clr", clr_a, 0);
    chk("rrun_valid", valid_a, 0);
    chk("rrun_busy", busy_a, 0);
    chk("rrun_lost", lost_a, 0);
    chk("rrun_data", data_a, 0);
    chk("rrun_ovf", capovf_a, 0);
    @(negedge clk); rst = 1'b0;
    // 6: both-edge mode, 10/30 duty, glitch inside the long low phase
    @(negedge clk); arm_b = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < lens[i]; k++) begin
        @(negedge clk);
        if (k == 0) evt_b = ~evt_b;
        if (k == 15 && !evt_b) begin #1 evt_b = 1'b1; #2 evt_b = 1'b0; end
        #1;
        if (k == 4 && i > 0) begin
          chk("both_valid", valid_b, 1);
          chk("both_data", data_b, lens[i-1] - 1);
          chk("both_ovf", capovf_b, 0);
        end
        if (k == 20) chk("glitch_none", valid_b, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
